ov_dvp_tx: RTL and testbench



---
 rtl/ov_dvp_tx_pkg.sv | 33 +++
 rtl/ov_dvp_tx_if.sv | 11 +
 rtl/ov_pclk_gen.sv | 38 +++
 rtl/ov_dvp_tx.sv | 172 +++++++++++++++++
 tb/tb_ov_dvp_tx.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov_dvp_tx_pkg.sv
// Shared types and constants for the DVP test-frame transmitter:
// FSM state encoding, pattern-select codes and the pattern byte function.
package ov_dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } ov_state_e;

    localparam logic [1:0] PAT_XRAMP = 2'd0;
    localparam logic [1:0] PAT_YRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    // Byte for active pixel (x, y); x and y are already truncated to 8 bits.
    function automatic logic [7:0] pat_byte(input logic [1:0] sel,
                                            input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] k);
        logic [7:0] b;
        case (sel)
            PAT_XRAMP: b = x;
            PAT_YRAMP: b = y;
            PAT_CHECK: b = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default:   b = k;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ov_dvp_tx_if.sv
// DVP sensor pin bundle: pixel clock, frame/line syncs and pixel byte.
// The transmitter drives it through the master modport, receivers use slave.
interface ov_dvp_tx_if;
    logic       ov_pclk;
    logic       ov_vsync;
    logic       ov_href;
    logic [7:0] ov_data;

    modport master (output ov_pclk, output ov_vsync, output ov_href, output ov_data);
    modport slave  (input  ov_pclk, input  ov_vsync, input  ov_href, input  ov_data);
endinterface

// File: rtl/ov_pclk_gen.sv
// Free-running pixel-clock divider. pclk toggles every PCLK_DIV clk_sys
// cycles; fall_tick marks the cycle whose closing edge drives pclk low, so
// logic updated on fall_tick changes together with the falling pclk edge.
module ov_pclk_gen #(
    parameter int PCLK_DIV = 2
) (
    input  logic clk_sys,
    input  logic rst,
    output logic pclk,
    output logic fall_tick
);
    localparam int CW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pclk_q, pclk_d;
    logic          wrap;

    // Half-period counter and toggle decision.
    always_comb begin
        wrap   = (cnt_q == CW'(PCLK_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pclk_d = wrap ? ~pclk_q : pclk_q;
    end

    // Divider registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign pclk      = pclk_q;
    assign fall_tick = wrap & pclk_q;
endmodule

// File: rtl/ov_dvp_tx.sv
// DVP camera-sensor transmitter producing OV-style test frames.
// Optional build macro OV_DVP_TX_FCNT_EN adds a 16-bit frame counter that
// replaces bytes x=0/x=1 of the first active line with fcnt[15:8]/fcnt[7:0].
module ov_dvp_tx
    import ov_dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10,
    parameter int PCLK_DIV = 2
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        pat_sel,
    input  logic [7:0]        pat_const,
    ov_dvp_tx_if.master       dvp,
    output logic              frame_done,
    output logic              busy
);
    localparam int LINE  = H_ACTIVE + H_BLANK;
    localparam int CW    = $clog2(LINE) + 1;
    localparam int VM1   = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int VM2   = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int V_MAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int RW    = $clog2(V_MAX) + 1;

    logic      pclk_w, fall_tick;
    ov_state_e state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] const_q, const_d;
    logic       vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
    logic [7:0] data_q, data_d;
    logic       line_end, start, frame_end;
`ifdef OV_DVP_TX_FCNT_EN
    logic [15:0] fcnt_q, fcnt_d;
`endif

    ov_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .pclk      (pclk_w),
        .fall_tick (fall_tick)
    );

    // Frame FSM: position, phase and output bytes advance only on fall_tick;
    // outputs are derived from the next position so they leave with pclk low.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        sel_d     = sel_q;
        const_d   = const_q;
        vsync_d   = vsync_q;
        href_d    = href_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        start     = 1'b0;
        frame_end = 1'b0;
        line_end  = (col_q == CW'(LINE - 1));
`ifdef OV_DVP_TX_FCNT_EN
        fcnt_d    = fcnt_q;
`endif
        if (fall_tick) begin
            col_d = line_end ? '0 : col_q + 1'b1;
            row_d = line_end ? row_q + 1'b1 : row_q;
            unique case (state_q)
                ST_IDLE: begin
                    col_d = '0;
                    row_d = '0;
                    start = en;
                end
                ST_VSYNC: if (line_end && row_q == RW'(VS_LINES - 1)) begin
                    row_d   = '0;
                    state_d = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
                end
                ST_VBACK: if (line_end && row_q == RW'(V_BACK - 1)) begin
                    row_d   = '0;
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE: if (line_end && row_q == RW'(V_ACTIVE - 1)) begin
                    row_d = '0;
                    if (V_FRONT > 0) state_d = ST_VFRONT;
                    else             frame_end = 1'b1;
                end
                ST_VFRONT: if (line_end && row_q == RW'(V_FRONT - 1)) begin
                    row_d     = '0;
                    frame_end = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase

            // Frame end: pulse done, then chain straight into the next frame
            // or fall back to idle; en is only consulted here and in IDLE.
            if (frame_end) begin
                done_d = 1'b1;
`ifdef OV_DVP_TX_FCNT_EN
                fcnt_d = fcnt_q + 16'd1;
`endif
                if (en) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            if (start) begin
                state_d = ST_VSYNC;
                sel_d   = pat_sel;
                const_d = pat_const;
                busy_d  = 1'b1;
                col_d   = '0;
                row_d   = '0;
            end

            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (col_d < CW'(H_ACTIVE));
            data_d  = href_d ? pat_byte(sel_d, 8'(col_d), 8'(row_d), const_d) : 8'h00;
`ifdef OV_DVP_TX_FCNT_EN
            if (href_d && row_d == '0 && col_d == CW'(0)) data_d = fcnt_q[15:8];
            if (href_d && row_d == '0 && col_d == CW'(1)) data_d = fcnt_q[7:0];
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= 2'd0;
            const_q <= 8'h00;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OV_DVP_TX_FCNT_EN
            fcnt_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            const_q <= const_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OV_DVP_TX_FCNT_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign dvp.ov_pclk  = pclk_w;
    assign dvp.ov_vsync = vsync_q;
    assign dvp.ov_href  = href_q;
    assign dvp.ov_data  = data_q;
    assign frame_done   = done_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_ov_dvp_tx.sv
// Directed bench for ov_dvp_tx: a small-geometry instance (8x4 active,
// 84 pclk frames) for timing/control, a wider one (32x16) for the checker.
`timescale 1ns/1ps
module tb_ov_dvp_tx;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       rst, en, en_b;
    logic [1:0] pat_sel, pat_sel_b;
    logic [7:0] pat_const, pat_const_b;
    logic       frame_done, busy, frame_done_b, busy_b;

    ov_dvp_tx_if dvp ();
    ov_dvp_tx_if dvp_b ();

    ov_dvp_tx #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VS_LINES(1),
                .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)) dut (
        .clk_sys(clk_sys), .rst(rst), .en(en), .pat_sel(pat_sel),
        .pat_const(pat_const), .dvp(dvp.master),
        .frame_done(frame_done), .busy(busy));

    ov_dvp_tx #(.H_ACTIVE(32), .H_BLANK(4), .V_ACTIVE(16), .VS_LINES(1),
                .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)) dut_b (
        .clk_sys(clk_sys), .rst(rst), .en(en_b), .pat_sel(pat_sel_b),
        .pat_const(pat_const_b), .dvp(dvp_b.master),
        .frame_done(frame_done_b), .busy(busy_b));

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // ---------------- monitor, small instance ----------------
    int cyc = 0;
    logic pclk_p = 1'b0, vs_p = 1'b0, hr_p = 1'b0, vsclk_p = 1'b0;
    int frm = -1, line = -1, px = 0;
    logic [7:0] cap [0:7][0:3][0:7];
    int hwid [0:7][0:3];
    int vs_cnt [0:7];
    int nlines [0:7];
    int fd_cnt = 0, vs_rises = 0;
    int fd_time [0:7];
    int vs_time [0:7];

    always begin
        @(posedge clk_sys); #1;
        cyc++;
        if (frame_done === 1'b1) begin
            if (fd_cnt < 8) fd_time[fd_cnt] = cyc;
            fd_cnt++;
        end
        if (dvp.ov_vsync === 1'b1 && !vsclk_p) begin
            if (vs_rises < 8) vs_time[vs_rises] = cyc;
            vs_rises++;
        end
        vsclk_p = (dvp.ov_vsync === 1'b1);
        if (dvp.ov_pclk === 1'b1 && !pclk_p) begin
            if (dvp.ov_vsync === 1'b1 && !vs_p) begin
                frm++;
                line = -1;
            end
            if (frm >= 0 && frm < 8) begin
                if (dvp.ov_vsync === 1'b1) vs_cnt[frm]++;
                if (dvp.ov_href === 1'b1 && !hr_p) begin
                    line++;
                    px = 0;
                end
                if (dvp.ov_href === 1'b1 && line >= 0 && line < 4) begin
                    if (px < 8) cap[frm][line][px] = dvp.ov_data;
                    px++;
                    hwid[frm][line] = px;
                    nlines[frm] = line + 1;
                end
            end
            vs_p = (dvp.ov_vsync === 1'b1);
            hr_p = (dvp.ov_href === 1'b1);
        end
        pclk_p = (dvp.ov_pclk === 1'b1);
    end

    // ---------------- monitor, wide instance ----------------
    logic pclk_pb = 1'b0, hr_pb = 1'b0;
    int line_b = -1, px_b = 0, fd_b = 0, vs_b = 0;
    logic vs_pb = 1'b0;
    logic [7:0] cap_b [0:15][0:31];

    always begin
        @(posedge clk_sys); #1;
        if (frame_done_b === 1'b1) fd_b++;
        if (dvp_b.ov_vsync === 1'b1 && !vs_pb) begin
            vs_b++;
            line_b = -1;
        end
        vs_pb = (dvp_b.ov_vsync === 1'b1);
        if (dvp_b.ov_pclk === 1'b1 && !pclk_pb) begin
            if (dvp_b.ov_href === 1'b1 && !hr_pb) begin
                line_b++;
                px_b = 0;
            end
            if (dvp_b.ov_href === 1'b1 && line_b >= 0 && line_b < 16 && px_b < 32) begin
                cap_b[line_b][px_b] = dvp_b.ov_data;
                px_b++;
            end
            hr_pb = (dvp_b.ov_href === 1'b1);
        end
        pclk_pb = (dvp_b.ov_pclk === 1'b1);
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic wait_fd(input string tag, input int target, input int budget);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 64'(fd_cnt), 64'(target));
    endtask

    task automatic wait_vs(input string tag, input int target, input int budget);
        int n = 0;
        while (vs_rises < target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 64'(vs_rises), 64'(target));
    endtask

    function automatic logic [63:0] cap_line(input int f, input int l);
        logic [63:0] r;
        for (int x = 0; x < 8; x++) r[63-8*x -: 8] = cap[f][l][x];
        return r;
    endfunction

    function automatic logic [63:0] cap_b_grp(input int l, input int g);
        logic [63:0] r;
        for (int x = 0; x < 8; x++) r[63-8*x -: 8] = cap_b[l][8*g + x];
        return r;
    endfunction

    // Expected 8-byte active line (x=0 in the top byte) for the small geometry.
    function automatic logic [63:0] exp_line(input int sel, input int y,
                                             input logic [7:0] k, input int fc);
        logic [63:0] r;
        logic [7:0]  b;
        for (int x = 0; x < 8; x++) begin
            case (sel)
                0:       b = 8'(x);
                1:       b = 8'(y);
                2:       b = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
                default: b = k;
            endcase
`ifdef OV_DVP_TX_FCNT_EN
            if (y == 0 && x == 0) b = fc[15:8];
            if (y == 0 && x == 1) b = fc[7:0];
`else
            if (fc < 0) b = 8'h00;
`endif
            r[63-8*x -: 8] = b;
        end
        return r;
    endfunction

    task automatic check_frame(input int f, input int sel, input logic [7:0] k, input int fc);
        check($sformatf("f%0d_vsync_pclks", f), 64'(vs_cnt[f]), 64'd12);
        check($sformatf("f%0d_lines", f), 64'(nlines[f]), 64'd4);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("f%0d_l%0d_href_w", f, l), 64'(hwid[f][l]), 64'd8);
            check($sformatf("f%0d_l%0d_data", f, l), cap_line(f, l), exp_line(sel, l, k, fc));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int toggles, last_t, gmin, gmax, quiet, c_en, n;
        logic pc_prev;
        rst = 1'b1; en = 1'b0; pat_sel = 2'd0; pat_const = 8'h00;
        en_b = 1'b0; pat_sel_b = 2'd0; pat_const_b = 8'h00;
        step(3);
        check("rst_pclk",  64'(dvp.ov_pclk), 64'd0);
        check("rst_syncs", 64'({dvp.ov_vsync, dvp.ov_href}), 64'd0);
        check("rst_data",  64'(dvp.ov_data), 64'd0);
        check("rst_busy_done", 64'({busy, frame_done}), 64'd0);

        // 1: idle with divider running
        rst = 1'b0;
        toggles = 0; last_t = 0; gmin = 99; gmax = 0; quiet = 0; pc_prev = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (dvp.ov_pclk !== pc_prev) begin
                if (toggles > 0) begin
                    if (i - last_t < gmin) gmin = i - last_t;
                    if (i - last_t > gmax) gmax = i - last_t;
                end
                toggles++;
                last_t = i;
            end
            pc_prev = dvp.ov_pclk;
            if (dvp.ov_vsync !== 1'b0 || dvp.ov_href !== 1'b0 ||
                dvp.ov_data !== 8'h00 || busy !== 1'b0) quiet++;
        end
        check("idle_toggles", 64'(toggles), 64'd8);
        check("idle_gap_min", 64'(gmin), 64'd2);
        check("idle_gap_max", 64'(gmax), 64'd2);
        check("idle_quiet", 64'(quiet), 64'd0);

        // 2/4/5: back-to-back frames, en dropped and pattern changed mid-frame
        pat_sel = 2'd0;
        en = 1'b1;
        c_en = cyc;
        wait_vs("start_seen", 1, 40);
        check("start_latency", 64'(vs_time[0] - c_en), 64'd4);
        wait_fd("fd_two", 2, 800);
        step(200);
        check("busy_mid", 64'(busy), 64'd1);
        en = 1'b0;
        pat_sel = 2'd3;
        pat_const = 8'hA5;
        wait_fd("fd_three", 3, 400);
        check("busy_end", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("frame%0d_len", k), 64'(fd_time[k] - vs_time[k]), 64'd336);
            check_frame(k, 0, 8'h00, k);
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("no_gap%0d", k), 64'(vs_time[k+1]), 64'(fd_time[k]));
        step(400);
        check("idle_no_restart", 64'(vs_rises), 64'd3);
        check("idle_busy", 64'(busy), 64'd0);

        // 6: reset during ACTIVE row 2
        pat_sel = 2'd1;
        en = 1'b1;
        wait_vs("rst_frame_start", 4, 40);
        step(200);
        check("f3_l0_data", cap_line(3, 0), exp_line(1, 0, 8'h00, 3));
        check("f3_l1_data", cap_line(3, 1), exp_line(1, 1, 8'h00, 3));
        rst = 1'b1;
        en = 1'b0;
        step(1);
        check("midrst_outs", 64'({dvp.ov_pclk, dvp.ov_vsync, dvp.ov_href}), 64'd0);
        check("midrst_data", 64'(dvp.ov_data), 64'd0);
        check("midrst_busy_done", 64'({busy, frame_done}), 64'd0);
        rst = 1'b0;
        step(400);
        check("midrst_no_fd", 64'(fd_cnt), 64'd3);
        check("midrst_no_vs", 64'(vs_rises), 64'd4);

        // single constant frame after reset (en pulsed only up to the start)
        pat_sel = 2'd3;
        pat_const = 8'h5A;
        en = 1'b1;
        wait_vs("const_start", 5, 40);
        en = 1'b0;
        wait_fd("const_fd", 4, 400);
        check_frame(4, 3, 8'h5A, 0);

        // 3: checkerboard on the wide instance
        pat_sel_b = 2'd2;
        en_b = 1'b1;
        n = 0;
        while (vs_b < 1 && n < 40) begin step(1); n++; end
        en_b = 1'b0;
        check("chk_start", 64'(vs_b), 64'd1);
        n = 0;
        while (fd_b < 1 && n < 3000) begin step(1); n++; end
        check("chk_fd", 64'(fd_b), 64'd1);
        check("chk_lines", 64'(line_b + 1), 64'd16);
        check("chk_r0_g0", cap_b_grp(0, 0), 64'h0000000000000000);
        check("chk_r0_g1", cap_b_grp(0, 1), 64'hFFFFFFFFFFFFFFFF);
        check("chk_r0_g2", cap_b_grp(0, 2), 64'h0000000000000000);
        check("chk_r0_g3", cap_b_grp(0, 3), 64'hFFFFFFFFFFFFFFFF);
        check("chk_r8_g0", cap_b_grp(8, 0), 64'hFFFFFFFFFFFFFFFF);
        check("chk_r8_g1", cap_b_grp(8, 1), 64'h0000000000000000);
        check("chk_r8_g2", cap_b_grp(8, 2), 64'hFFFFFFFFFFFFFFFF);
        check("chk_r8_g3", cap_b_grp(8, 3), 64'h0000000000000000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
